// File: rtl/servo_pkg.sv
// Shared helpers for the multi-channel servo PWM generator: clock divider,
// counter widths and the position-to-pulse-width mapping.
package servo_pkg;

    function automatic int cnt_w(input int n);
        return (n <= 32'sd2) ? 32'sd1 : $clog2(n);
    endfunction

    function automatic int clk_div(input int clk_freq);
        return clk_freq / 32'sd1_000_000;
    endfunction

    // Product is formed at 64 bits so no bits are lost before the shift.
    function automatic int pulse_width(input int pos, input int pos_w,
                                       input int min_us, input int max_us);
        longint prod;
        prod = longint'(pos) * longint'(max_us - min_us);
        return min_us + int'(prod >> pos_w);
    endfunction

endpackage

// File: rtl/servo_ch.sv
// One servo channel: target latch, per-frame slew limiter, pulse-width
// register and the counter comparator that drives the pulse output.
module servo_ch
    import servo_pkg::*;
#(
    parameter int POS_W   = 8,
    parameter int FC_W    = 15,
    parameter int MIN_US  = 1000,
    parameter int MAX_US  = 2000,
    parameter int STEP    = 4,
    parameter int RST_POS = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             wrap_i,
    input  logic [FC_W-1:0]  fc_i,
    input  logic [POS_W-1:0] target_i,
    output logic [POS_W-1:0] cur_pos_o,
    output logic             pwm_o,
    output logic             busy_o
);

    localparam int FULL     = 32'sd1 << POS_W;
    localparam int STEP_SAT = (STEP >= FULL) ? (FULL - 32'sd1) : STEP;
    localparam logic [POS_W-1:0] STEP_V  = POS_W'(STEP_SAT);
    localparam logic [POS_W-1:0] RST_V   = POS_W'(RST_POS);
    localparam logic [FC_W-1:0]  RST_WID = FC_W'(pulse_width(RST_POS, POS_W, MIN_US, MAX_US));

    logic [POS_W-1:0] tgt_q, tgt_d, cur_q, cur_d, gap_s, slew_s;
    logic [FC_W-1:0]  wid_q, wid_d;
    logic             busy_q, busy_d, pwm_q, pwm_d;

    // Slew toward the newly latched target; the step saturates at the target.
    always_comb begin
        tgt_d  = tgt_q;
        gap_s  = '0;
        slew_s = cur_q;
        cur_d  = cur_q;
        wid_d  = wid_q;
        if (wrap_i) begin
            tgt_d = target_i;
        end else begin
            tgt_d = tgt_q;
        end
        if (tgt_d > cur_q) begin
            gap_s  = tgt_d - cur_q;
            slew_s = (gap_s <= STEP_V) ? tgt_d : (cur_q + STEP_V);
        end else begin
            gap_s  = cur_q - tgt_d;
            slew_s = (gap_s <= STEP_V) ? tgt_d : (cur_q - STEP_V);
        end
        if (wrap_i) begin
            cur_d = slew_s;
            wid_d = FC_W'(pulse_width(int'(slew_s), POS_W, MIN_US, MAX_US));
        end else begin
            cur_d = cur_q;
            wid_d = wid_q;
        end
        busy_d = (cur_d != tgt_d);
        pwm_d  = en_i && (fc_i < wid_q);
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tgt_q  <= RST_V;
            cur_q  <= RST_V;
            wid_q  <= RST_WID;
            busy_q <= 1'b0;
            pwm_q  <= 1'b0;
        end else begin
            tgt_q  <= tgt_d;
            cur_q  <= cur_d;
            wid_q  <= wid_d;
            busy_q <= busy_d;
            pwm_q  <= pwm_d;
        end
    end

    assign cur_pos_o = cur_q;
    assign pwm_o     = pwm_q;
    assign busy_o    = busy_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator: shared microsecond prescaler and
// frame counter feeding N_CH slew-limited channels.
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int N_CH      = 4,
    parameter int POS_W     = 8,
    parameter int PERIOD_US = 20000,
    parameter int MIN_US    = 1000,
    parameter int MAX_US    = 2000,
    parameter int STEP      = 4,
    parameter int RST_POS   = 2 ** (POS_W - 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [N_CH*POS_W-1:0] target,
    output logic [N_CH-1:0]       pwm,
    output logic [N_CH*POS_W-1:0] cur_pos,
    output logic                  frame_start,
    output logic                  busy
);

    localparam int DIV   = clk_div(CLK_FREQ);
    localparam int PRE_W = cnt_w(DIV);
    localparam int FC_W  = cnt_w(PERIOD_US);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 32'sd1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(PERIOD_US - 32'sd1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [FC_W-1:0]  fc_q, fc_d;
    logic             us_tick_s, wrap_s, fs_q;
    logic [N_CH-1:0]  ch_busy_s;

    // Prescaler and frame counter; disabling parks both at zero.
    always_comb begin
        us_tick_s = en && (pre_q == PRE_LAST);
        wrap_s    = us_tick_s && (fc_q == FC_LAST);
        pre_d     = pre_q;
        fc_d      = fc_q;
        if (!en) begin
            pre_d = '0;
            fc_d  = '0;
        end else if (us_tick_s) begin
            pre_d = '0;
            fc_d  = wrap_s ? '0 : (fc_q + FC_W'(1));
        end else begin
            pre_d = pre_q + PRE_W'(1);
            fc_d  = fc_q;
        end
    end

    // Timebase registers and the frame boundary strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
            fc_q  <= '0;
            fs_q  <= 1'b0;
        end else begin
            pre_q <= pre_d;
            fc_q  <= fc_d;
            fs_q  <= wrap_s;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        servo_ch #(
            .POS_W  (POS_W),
            .FC_W   (FC_W),
            .MIN_US (MIN_US),
            .MAX_US (MAX_US),
            .STEP   (STEP),
            .RST_POS(RST_POS)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en_i     (en),
            .wrap_i   (wrap_s),
            .fc_i     (fc_q),
            .target_i (target[i*POS_W +: POS_W]),
            .cur_pos_o(cur_pos[i*POS_W +: POS_W]),
            .pwm_o    (pwm[i]),
            .busy_o   (ch_busy_s[i])
        );
    end

    assign frame_start = fs_q;
    assign busy        = |ch_busy_s;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Self-checking bench for servo_pwm_multi: directed scenarios plus random
// targets/enable toggling, checked every clock against an elapsed-time model.
module tb_servo_pwm_multi;

    localparam int CLK_FREQ  = 2_000_000;
    localparam int N_CH      = 2;
    localparam int POS_W     = 4;
    localparam int PERIOD_US = 100;
    localparam int MIN_US    = 10;
    localparam int MAX_US    = 20;
    localparam int STEP      = 2;
    localparam int RST_POS   = 8;
    localparam int DIV       = CLK_FREQ / 1_000_000;
    localparam int FRAME_CLK = DIV * PERIOD_US;

    logic       clk, rst_n, en;
    logic [7:0] target;
    logic [1:0] pwm;
    logic [7:0] cur_pos;
    logic       frame_start, busy;

    int checks, errors;
    int n;
    int cur_m[2];
    int wid_m[2];
    bit pwm_m[2];
    bit fs_m, busy_m;
    int h0, h1;

    servo_pwm_multi #(
        .CLK_FREQ(CLK_FREQ), .N_CH(N_CH), .POS_W(POS_W), .PERIOD_US(PERIOD_US),
        .MIN_US(MIN_US), .MAX_US(MAX_US), .STEP(STEP), .RST_POS(RST_POS)
    ) dut (
        .clk(clk), .rst(rst_n), .en(en), .target(target), .pwm(pwm),
        .cur_pos(cur_pos), .frame_start(frame_start), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int width_of(input int pos);
        return MIN_US + (pos * (MAX_US - MIN_US)) / (2 ** POS_W);
    endfunction

    task automatic model_reset();
        n      = 0;
        fs_m   = 1'b0;
        busy_m = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            cur_m[i] = RST_POS;
            wid_m[i] = width_of(RST_POS);
            pwm_m[i] = 1'b0;
        end
    endtask

    // n counts clocks since the timebase last started from zero.
    task automatic model_edge();
        int cnt, t, d;
        if (!rst_n) begin
            model_reset();
        end else if (!en) begin
            n    = 0;
            fs_m = 1'b0;
            for (int i = 0; i < N_CH; i++) pwm_m[i] = 1'b0;
        end else begin
            cnt = (n / DIV) % PERIOD_US;
            for (int i = 0; i < N_CH; i++) pwm_m[i] = (cnt < wid_m[i]);
            n++;
            fs_m = ((n % FRAME_CLK) == 0);
            if (fs_m) begin
                busy_m = 1'b0;
                for (int i = 0; i < N_CH; i++) begin
                    t = int'(target[i*POS_W +: POS_W]);
                    d = t - cur_m[i];
                    if (d > STEP)       cur_m[i] += STEP;
                    else if (d < -STEP) cur_m[i] -= STEP;
                    else                cur_m[i] = t;
                    wid_m[i] = width_of(cur_m[i]);
                    if (cur_m[i] != t) busy_m = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("pwm", 32'(pwm), 32'({pwm_m[1], pwm_m[0]}));
        check("cur_pos", 32'(cur_pos), 32'(cur_m[1] * 16 + cur_m[0]));
        check("frame_start", 32'(frame_start), 32'(fs_m));
        check("busy", 32'(busy), 32'(busy_m));
    endtask

    task automatic run(input int cycles, output int hi0, output int hi1);
        hi0 = 0;
        hi1 = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            hi0 += int'(pwm[0]);
            hi1 += int'(pwm[1]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        target = 8'h88;
        model_reset();
        for (int k = 0; k < 3; k++) tick();
        check("rst_cur_pos", 32'(cur_pos), 32'h88);
        check("rst_pwm", 32'(pwm), 32'd0);

        // Steady mid position: 15 us pulses on both channels.
        rst_n = 1'b1;
        en    = 1'b1;
        run(FRAME_CLK, h0, h1);
        check("mid_pulse0", 32'(h0), 32'd30);
        check("mid_pulse1", 32'(h1), 32'd30);

        // Ch0 ramps 8 -> 15 in five frames.
        target = 8'h8F;
        run(5 * FRAME_CLK, h0, h1);
        check("ramp_up_cur", 32'(cur_pos), 32'h8F);
        check("ramp_up_busy", 32'(busy), 32'd0);
        run(FRAME_CLK, h0, h1);
        check("full_pulse0", 32'(h0), 32'd38);
        check("mid_pulse1b", 32'(h1), 32'd30);

        // Ch1 ramps 8 -> 0 while ch0 stays put.
        target = 8'h0F;
        run(5 * FRAME_CLK, h0, h1);
        check("ramp_dn_cur", 32'(cur_pos), 32'h0F);

        // Drop enable during the pulse, then restore.
        for (int k = 0; k < FRAME_CLK && (n % FRAME_CLK) != 10; k++) tick();
        en = 1'b0;
        run(40, h0, h1);
        check("en_off_pwm", 32'(h0 + h1), 32'd0);
        check("en_off_cur", 32'(cur_pos), 32'h0F);
        en = 1'b1;
        run(FRAME_CLK, h0, h1);
        check("en_on_pulse0", 32'(h0), 32'd38);
        check("en_on_pulse1", 32'(h1), 32'd20);

        // Asynchronous reset in the middle of a ramp and a pulse.
        target = 8'h00;
        for (int k = 0; k < 2 * FRAME_CLK && !((n % FRAME_CLK) == 10 && cur_m[0] != 15); k++) tick();
        check("pre_rst_pwm0", 32'(pwm[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pwm", 32'(pwm), 32'd0);
        check("arst_cur", 32'(cur_pos), 32'h88);
        check("arst_busy", 32'(busy), 32'd0);
        model_reset();
        for (int k = 0; k < 2; k++) tick();
        rst_n  = 1'b1;
        target = 8'h88;
        run(FRAME_CLK, h0, h1);
        check("post_rst_pulse0", 32'(h0), 32'd30);

        // Random targets (often mid-frame) and enable toggling.
        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(0, 149) == 0) target = 8'($urandom);
            if (en) begin
                if ($urandom_range(0, 999) < 2) en = 1'b0;
            end else if ($urandom_range(0, 49) == 0) begin
                en = 1'b1;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
